// File: rtl/wb_write_queue.sv
// Writeback write-request queue: merges load and ALU register writes in order,
// retires one per cycle to the register file and publishes a per-register pending mask.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_valid,
  input  logic [3:0]               mem_reg,
  input  logic [DW-1:0]            mem_data,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [3:0]               alu_reg,
  input  logic [DW-1:0]            alu_data,
  output logic                     alu_ready,
  input  logic                     wb_hold,
  output logic                     WriteReg,
  output logic [3:0]               DstReg,
  output logic [DW-1:0]            DstData,
  output logic [15:0]              pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]       reg_q  [DEPTH];
  logic [3:0]       reg_d  [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic          full, empty;
  logic          mem_push, alu_push, push, pop;
  logic [3:0]    push_reg;
  logic [DW-1:0] push_data;

  // Handshake and retire decisions depend only on registered occupancy,
  // so a retire in the same cycle never frees a slot for an enqueue.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    mem_ready = ~full;
    alu_ready = ~full & ~mem_valid;
    mem_push  = mem_valid & mem_ready;
    alu_push  = alu_valid & alu_ready;
    push      = mem_push | alu_push;
    push_reg  = mem_push ? mem_reg  : alu_reg;
    push_data = mem_push ? mem_data : alu_data;
    WriteReg  = ~empty & ~wb_hold;
    pop       = WriteReg;
    DstReg    = empty ? '0 : reg_q[rd_ptr_q];
    DstData   = empty ? '0 : data_q[rd_ptr_q];
    count     = count_q;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pending[reg_q[i]] = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block infers a latch.
    reg_d    = reg_q;
    data_d   = data_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push) begin
      reg_d[wr_ptr_q]  = push_reg;
      data_d[wr_ptr_q] = push_data;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: payload storage is not reset; the valid bits and the empty mask keep
  // stale contents from ever reaching the outputs.
  always_ff @(posedge clk) begin
    reg_q  <= reg_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue: reset, single write, collision,
// fill under hold, pointer wrap against a scoreboard, and reset mid-operation.
module tb_wb_write_queue;

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [3:0]  mem_reg;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        alu_valid;
  logic [3:0]  alu_reg;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        wb_hold;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [15:0] pending;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  wb_write_queue #(.DEPTH(4), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_reg   (mem_reg),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .alu_valid (alu_valid),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .wb_hold   (wb_hold),
    .WriteReg  (WriteReg),
    .DstReg    (DstReg),
    .DstData   (DstData),
    .pending   (pending),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_hold = 1'b0;
    mem_valid = 1'b1; mem_reg = 4'd7; mem_data = 16'hFFFF;
    alu_valid = 1'b1; alu_reg = 4'd9; alu_data = 16'hEEEE;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", WriteReg); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL reset_pending: got %h want 0000", pending); end
    end
    rst = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %0b want 1", mem_ready); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %0b want 1", alu_ready); end
    checks++; if (DstReg !== 4'd0) begin errors++; $display("FAIL reset_dstreg: got %0d want 0", DstReg); end
    checks++; if (DstData !== 16'h0000) begin errors++; $display("FAIL reset_dstdata: got %h want 0000", DstData); end
  endtask

  task automatic test_single_alu();
    step();
    alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 16'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b want 1", alu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (WriteReg !== 1'b1) begin errors++; $display("FAIL single_we: got %0b want 1", WriteReg); end
    checks++; if (DstReg !== 4'd5) begin errors++; $display("FAIL single_dstreg: got %0d want 5", DstReg); end
    checks++; if (DstData !== 16'h1234) begin errors++; $display("FAIL single_dstdata: got %h want 1234", DstData); end
    checks++; if (pending !== 16'h0020) begin errors++; $display("FAIL single_pending: got %h want 0020", pending); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
    step();
    checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL single_we_after: got %0b want 0", WriteReg); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_after: got %0d want 0", count); end
    checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL single_pending_after: got %h want 0000", pending); end
  endtask

  task automatic test_collision();
    wb_hold = 1'b0;
    mem_valid = 1'b1; mem_reg = 4'd3; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'h5555;
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL coll_alu_ready: got %0b want 0", alu_ready); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL coll_mem_ready: got %0b want 1", mem_ready); end
    step();
    mem_valid = 1'b0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL coll_alu_ready2: got %0b want 1", alu_ready); end
    checks++; if (WriteReg !== 1'b1) begin errors++; $display("FAIL coll_we1: got %0b want 1", WriteReg); end
    checks++; if (DstData !== 16'hAAAA) begin errors++; $display("FAIL coll_first: got %h want aaaa", DstData); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL coll_count1: got %0d want 1", count); end
    checks++; if (pending !== 16'h0008) begin errors++; $display("FAIL coll_pending1: got %h want 0008", pending); end
    step();
    alu_valid = 1'b0;
    checks++; if (DstData !== 16'h5555) begin errors++; $display("FAIL coll_second: got %h want 5555", DstData); end
    checks++; if (DstReg !== 4'd3) begin errors++; $display("FAIL coll_dstreg: got %0d want 3", DstReg); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL coll_count2: got %0d want 1", count); end
    checks++; if (WriteReg !== 1'b1) begin errors++; $display("FAIL coll_we2: got %0b want 1", WriteReg); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL coll_count3: got %0d want 0", count); end
    checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL coll_pending3: got %h want 0000", pending); end
  endtask

  task automatic test_fill_hold();
    wb_hold = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      alu_valid = 1'b1; alu_reg = 4'(r); alu_data = 16'(16'h1000 + r);
      step();
    end
    alu_reg = 4'd5; alu_data = 16'h1005;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL fill_mem_ready: got %0b want 0", mem_ready); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL fill_alu_ready: got %0b want 0", alu_ready); end
    checks++; if (pending !== 16'h001E) begin errors++; $display("FAIL fill_pending: got %h want 001e", pending); end
    checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL fill_we_held: got %0b want 0", WriteReg); end
    step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count_full: got %0d want 4", count); end
    wb_hold = 1'b0;
    #1;
    checks++; if (WriteReg !== 1'b1 || DstReg !== 4'd1) begin errors++; $display("FAIL fill_ret1: got we=%0b reg=%0d want we=1 reg=1", WriteReg, DstReg); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL fill_full_retire_ready: got %0b want 0", alu_ready); end
    step();
    checks++; if (count !== 3'd3 || DstReg !== 4'd2 || WriteReg !== 1'b1) begin errors++; $display("FAIL fill_ret2: got cnt=%0d reg=%0d we=%0b want cnt=3 reg=2 we=1", count, DstReg, WriteReg); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_again: got %0b want 1", alu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (count !== 3'd3 || DstReg !== 4'd3 || WriteReg !== 1'b1) begin errors++; $display("FAIL fill_ret3: got cnt=%0d reg=%0d we=%0b want cnt=3 reg=3 we=1", count, DstReg, WriteReg); end
    checks++; if (pending !== 16'h0038) begin errors++; $display("FAIL fill_pending2: got %h want 0038", pending); end
    step();
    checks++; if (count !== 3'd2 || DstReg !== 4'd4 || WriteReg !== 1'b1) begin errors++; $display("FAIL fill_ret4: got cnt=%0d reg=%0d we=%0b want cnt=2 reg=4 we=1", count, DstReg, WriteReg); end
    step();
    checks++; if (count !== 3'd1 || DstReg !== 4'd5 || DstData !== 16'h1005) begin errors++; $display("FAIL fill_ret5: got cnt=%0d reg=%0d data=%h want cnt=1 reg=5 data=1005", count, DstReg, DstData); end
    step();
    checks++; if (count !== 3'd0 || WriteReg !== 1'b0) begin errors++; $display("FAIL fill_drained: got cnt=%0d we=%0b want cnt=0 we=0", count, WriteReg); end
  endtask

  task automatic test_wrap();
    wr_t         exp_q[$];
    int          acc = 0;
    int          cyc = 0;
    logic        exp_ready, exp_we;
    logic [15:0] exp_pend;
    mem_valid = 1'b0; alu_valid = 1'b0;
    while ((acc < 10 || exp_q.size() != 0) && cyc < 200) begin
      if (acc < 10 && acc % 2 == 0) begin
        mem_valid = 1'b1; mem_reg = 4'((acc * 3) % 16); mem_data = 16'(16'hC000 + acc);
        alu_valid = 1'b0;
      end else if (acc < 10) begin
        alu_valid = 1'b1; alu_reg = 4'((acc * 3) % 16); alu_data = 16'(16'hC000 + acc);
        mem_valid = 1'b0;
      end else begin
        mem_valid = 1'b0; alu_valid = 1'b0;
      end
      wb_hold = ($urandom_range(0, 1) == 1);
      #1;
      exp_ready = (exp_q.size() < 4);
      exp_we    = (exp_q.size() != 0) && !wb_hold;
      exp_pend  = '0;
      foreach (exp_q[k]) exp_pend[exp_q[k].r] = 1'b1;
      checks++; if (mem_ready !== exp_ready) begin errors++; $display("FAIL wrap_mem_ready cyc %0d: got %0b want %0b", cyc, mem_ready, exp_ready); end
      checks++; if (alu_ready !== (exp_ready & ~mem_valid)) begin errors++; $display("FAIL wrap_alu_ready cyc %0d: got %0b want %0b", cyc, alu_ready, exp_ready & ~mem_valid); end
      checks++; if (WriteReg !== exp_we) begin errors++; $display("FAIL wrap_we cyc %0d: got %0b want %0b", cyc, WriteReg, exp_we); end
      checks++; if (count !== 3'(exp_q.size())) begin errors++; $display("FAIL wrap_count cyc %0d: got %0d want %0d", cyc, count, exp_q.size()); end
      checks++; if (pending !== exp_pend) begin errors++; $display("FAIL wrap_pending cyc %0d: got %h want %h", cyc, pending, exp_pend); end
      if (exp_q.size() != 0) begin
        checks++;
        if (DstReg !== exp_q[0].r || DstData !== exp_q[0].d) begin
          errors++;
          $display("FAIL wrap_head cyc %0d: got reg=%0d data=%h want reg=%0d data=%h", cyc, DstReg, DstData, exp_q[0].r, exp_q[0].d);
        end
      end
      step();
      if (exp_we) void'(exp_q.pop_front());
      if (exp_ready && (mem_valid || alu_valid)) begin
        exp_q.push_back(wr_t'{r: 4'((acc * 3) % 16), d: 16'(16'hC000 + acc)});
        acc++;
      end
      cyc++;
    end
    mem_valid = 1'b0; alu_valid = 1'b0; wb_hold = 1'b0;
    checks++; if (cyc >= 200) begin errors++; $display("FAIL wrap_timeout: got %0d cycles want < 200", cyc); end
  endtask

  task automatic test_reset_mid();
    wb_hold = 1'b1;
    for (int r = 10; r <= 12; r++) begin
      alu_valid = 1'b1; alu_reg = 4'(r); alu_data = 16'(16'hD000 + r);
      step();
    end
    alu_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rmid_count: got %0d want 3", count); end
    checks++; if (pending !== 16'h1C00) begin errors++; $display("FAIL rmid_pending: got %h want 1c00", pending); end
    rst = 1'b1;
    step();
    rst = 1'b0; wb_hold = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count_after: got %0d want 0", count); end
    checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL rmid_pending_after: got %h want 0000", pending); end
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL rmid_we cyc %0d: got %0b want 0", c, WriteReg); end
      step();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count_final: got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_collision();
    test_fill_hold();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
